// File: rtl/glycemic_index_tracker.sv
// glycemic_index_tracker: per-sample popcount of |sample| with per-channel
// moving-average history and sticky threshold alarms.
`default_nettype none

module glycemic_index_tracker #(
  parameter int DATA_W   = 8,
  parameter int CHANNELS = 4,
  parameter int WINDOW   = 4,
  parameter int ALARM_TH = 4,
  localparam int CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  localparam int IDX_W   = $clog2(DATA_W + 1)
) (
  input  logic                clk,
  input  logic                rstN,
  input  logic                sampleValid,
  input  logic [CH_W-1:0]     sampleChannel,
  input  logic [DATA_W-1:0]   bloodSensor,
  input  logic [CHANNELS-1:0] clearAlarm,
  output logic                sampleReady,
  output logic                resultValid,
  output logic [CH_W-1:0]     resultChannel,
  output logic [IDX_W-1:0]    glycemicIndex,
  output logic [IDX_W-1:0]    avgIndex,
  output logic                chanErr,
  output logic [CHANNELS-1:0] alarm
);

  localparam int WIN_LOG = $clog2(WINDOW);
  localparam int SUM_W   = IDX_W + WIN_LOG;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ABS    = 3'd1;
  localparam logic [2:0] S_COUNT  = 3'd2;
  localparam logic [2:0] S_UPDATE = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  logic [2:0]        state, state_next;
  logic [DATA_W-1:0] sample_q, mag_q;
  logic [CH_W-1:0]   chan_q;
  logic [IDX_W-1:0]  pop_q, bit_cnt;
  logic [IDX_W-1:0]  avg_sel;
  logic [IDX_W-1:0]  avg_ch [CHANNELS];
  logic              chan_ok;

  assign chan_ok = ({1'b0, chan_q} < (CH_W + 1)'(CHANNELS));

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:   if (sampleValid) state_next = S_ABS;
      S_ABS:    state_next = S_COUNT;
      S_COUNT:  if (bit_cnt == IDX_W'(DATA_W - 1)) state_next = S_UPDATE;
      S_UPDATE: state_next = S_DONE;
      S_DONE:   state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  always_comb begin
    sampleReady = (state == S_IDLE);
    resultValid = (state == S_DONE);
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      sample_q      <= '0;
      mag_q         <= '0;
      chan_q        <= '0;
      pop_q         <= '0;
      bit_cnt       <= '0;
      glycemicIndex <= '0;
      avgIndex      <= '0;
      resultChannel <= '0;
      chanErr       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (sampleValid) begin
            sample_q <= bloodSensor;
            chan_q   <= sampleChannel;
          end
        end
        S_ABS: begin
          mag_q   <= sample_q[DATA_W-1] ? (~sample_q + DATA_W'(1)) : sample_q;
          pop_q   <= '0;
          bit_cnt <= '0;
        end
        S_COUNT: begin
          mag_q   <= mag_q >> 1;
          pop_q   <= pop_q + IDX_W'(mag_q[0]);
          bit_cnt <= bit_cnt + IDX_W'(1);
        end
        S_UPDATE: begin
          glycemicIndex <= pop_q;
          resultChannel <= chan_q;
          chanErr       <= !chan_ok;
          avgIndex      <= chan_ok ? avg_sel : '0;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    avg_sel = '0;
    for (int c = 0; c < CHANNELS; c++)
      if (chan_q == CH_W'(c)) avg_sel = avg_ch[c];
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
    logic [IDX_W-1:0] hist [WINDOW];
    logic [SUM_W-1:0] sum_q, sum_next;
    logic             hit, alarm_q, over_th;

    assign hit      = (state == S_UPDATE) && chan_ok && (chan_q == CH_W'(c));
    // Oldest entry drops out as the new index enters; history starts at zero.
    assign sum_next = sum_q + SUM_W'(pop_q) - SUM_W'(hist[WINDOW-1]);
    assign avg_ch[c] = IDX_W'(sum_next >> WIN_LOG);
    assign over_th  = ($unsigned(32'(avg_ch[c])) >= $unsigned(32'(ALARM_TH)));
    assign alarm[c] = alarm_q;

    always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
        for (int i = 0; i < WINDOW; i++) hist[i] <= '0;
        sum_q   <= '0;
        alarm_q <= 1'b0;
      end else begin
        if (hit) begin
          hist[0] <= pop_q;
          for (int i = 1; i < WINDOW; i++) hist[i] <= hist[i-1];
          sum_q <= sum_next;
        end
        if (hit && over_th)     alarm_q <= 1'b1;
        else if (clearAlarm[c]) alarm_q <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_glycemic_index_tracker.sv
// Bench: two tracker instances (4 and 3 channels) share stimulus; a queue of
// model-predicted results is compared against each result strobe.
`default_nettype none

module tb_glycemic_index_tracker;

  logic       clk = 1'b0;
  logic       rstN = 1'b0;
  logic       sampleValid = 1'b0;
  logic [1:0] sampleChannel = '0;
  logic [7:0] bloodSensor = '0;
  logic [3:0] clearAlarm = '0;

  logic       ready1, rv1, err1;
  logic [1:0] ch1;
  logic [3:0] gi1, avg1, alarm1;
  logic       ready2, rv2, err2;
  logic [1:0] ch2;
  logic [3:0] gi2, avg2;
  logic [2:0] alarm2;

  int checks = 0;
  int failures = 0;

  typedef struct {
    int gi; int ch;
    int avg0; int avg1; int err0; int err1;
    logic [3:0] al0; logic [3:0] al1;
  } exp_t;

  exp_t q[$];
  int   hist[2][4][4];
  int   al[2][4];

  glycemic_index_tracker #(.DATA_W(8), .CHANNELS(4), .WINDOW(4), .ALARM_TH(4)) dut1 (
    .clk(clk), .rstN(rstN), .sampleValid(sampleValid), .sampleChannel(sampleChannel),
    .bloodSensor(bloodSensor), .clearAlarm(clearAlarm), .sampleReady(ready1),
    .resultValid(rv1), .resultChannel(ch1), .glycemicIndex(gi1), .avgIndex(avg1),
    .chanErr(err1), .alarm(alarm1));

  glycemic_index_tracker #(.DATA_W(8), .CHANNELS(3), .WINDOW(4), .ALARM_TH(4)) dut2 (
    .clk(clk), .rstN(rstN), .sampleValid(sampleValid), .sampleChannel(sampleChannel),
    .bloodSensor(bloodSensor), .clearAlarm(clearAlarm[2:0]), .sampleReady(ready2),
    .resultValid(rv2), .resultChannel(ch2), .glycemicIndex(gi2), .avgIndex(avg2),
    .chanErr(err2), .alarm(alarm2));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++)
      for (int c = 0; c < 4; c++) begin
        al[k][c] = 0;
        for (int i = 0; i < 4; i++) hist[k][c][i] = 0;
      end
  endtask

  function automatic logic [3:0] pack_al(input int k);
    logic [3:0] v;
    for (int j = 0; j < 4; j++) v[j] = (al[k][j] != 0);
    return v;
  endfunction

  task automatic send(input int ch, input logic [7:0] d, input bit clr);
    exp_t e, got;
    int sv, mag, nch, s, avg, lat, bad;
    bit set;
    sv  = int'($signed(d));
    mag = (sv < 0) ? -sv : sv;
    e.gi = $countones(mag);
    e.ch = ch;
    for (int k = 0; k < 2; k++) begin
      nch = (k == 0) ? 4 : 3;
      avg = 0;
      set = 1'b0;
      if (ch < nch) begin
        for (int i = 3; i > 0; i--) hist[k][ch][i] = hist[k][ch][i-1];
        hist[k][ch][0] = e.gi;
        s = 0;
        for (int i = 0; i < 4; i++) s += hist[k][ch][i];
        avg = s / 4;
        set = (avg >= 4);
        if (set) al[k][ch] = 1;
      end
      if (clr && !(set && ch == 2)) al[k][2] = 0;
      if (k == 0) begin e.avg0 = avg; e.err0 = (ch >= nch); e.al0 = pack_al(0); end
      else        begin e.avg1 = avg; e.err1 = (ch >= nch); e.al1 = pack_al(1); end
    end
    q.push_back(e);

    chk("ready_before", ready1, 1);
    sampleValid = 1'b1;
    sampleChannel = 2'(ch);
    bloodSensor = d;
    @(negedge clk);
    sampleValid = 1'b0;
    lat = 1;
    bad = 0;
    while (!rv1 && lat < 20) begin
      if (ready1) bad++;
      clearAlarm = (clr && lat == 10) ? 4'b0100 : 4'b0000;
      @(negedge clk);
      lat++;
    end
    clearAlarm = '0;
    got = q.pop_front();
    chk("latency", lat, 11);
    chk("ready_low_busy", bad, 0);
    chk("rv2", rv2, 1);
    chk("gi1", gi1, got.gi);
    chk("avg1", avg1, got.avg0);
    chk("err1", err1, got.err0);
    chk("ch1", ch1, got.ch);
    chk("alarm1", alarm1, got.al0);
    chk("gi2", gi2, got.gi);
    chk("avg2", avg2, got.avg1);
    chk("err2", err2, got.err1);
    chk("ch2", ch2, got.ch);
    chk("alarm2", alarm2, got.al1[2:0]);
    @(negedge clk);
    chk("rv_strobe", rv1, 0);
    chk("ready_after", ready1, 1);
  endtask

  initial begin
    int bad;
    logic [3:0] a;
    model_reset();
    repeat (3) @(negedge clk);
    rstN = 1'b1;
    @(negedge clk);
    chk("rst_ready", ready1, 1);
    chk("rst_rv", rv1, 0);
    chk("rst_gi", gi1, 0);
    chk("rst_avg", avg1, 0);
    chk("rst_err", err1, 0);
    chk("rst_ch", ch1, 0);
    chk("rst_alarm", alarm1, 0);

    send(0, 8'h7F, 0);
    send(1, 8'h80, 0);
    send(1, 8'hFF, 0);
    send(3, 8'h00, 0);
    send(3, 8'h7F, 0);
    send(0, 8'h00, 0);
    send(2, 8'h7F, 0);
    send(2, 8'h7F, 0);
    send(2, 8'h7F, 0);
    send(2, 8'h7F, 1);

    clearAlarm = 4'b0100;
    @(negedge clk);
    clearAlarm = '0;
    al[0][2] = 0;
    al[1][2] = 0;
    a = pack_al(0);
    chk("idle_clear1", alarm1, a);
    chk("idle_clear2", alarm2, a[2:0]);

    sampleValid = 1'b1;
    sampleChannel = 2'd1;
    bloodSensor = 8'h55;
    @(negedge clk);
    sampleValid = 1'b0;
    repeat (4) @(negedge clk);
    rstN = 1'b0;
    #1;
    model_reset();
    chk("arst_rv", rv1, 0);
    chk("arst_gi", gi1, 0);
    chk("arst_avg", avg1, 0);
    chk("arst_err", err1, 0);
    chk("arst_ch", ch1, 0);
    chk("arst_alarm", alarm1, 0);
    @(negedge clk);
    rstN = 1'b1;
    bad = 0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (rv1 || !ready1) bad++;
    end
    chk("arst_idle", bad, 0);
    send(0, 8'h7F, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/glycemic_index_tracker.md
GLYCEMIC_INDEX_TRACKER -- requirements
Module: glycemic_index_tracker

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8: signed two's-complement sensor sample width, minimum 2.
REQ-002 The block SHALL have parameter CHANNELS, default 4: number of tracked sensor channels, 1..16.
REQ-003 The block SHALL have parameter WINDOW, default 4: moving-average depth per channel, a power of two, 1..16.
REQ-004 The block SHALL have parameter ALARM_TH, default 4: alarm threshold on the averaged index.
REQ-005 Derived widths SHALL be CH_W = max(1, clog2(CHANNELS)) and IDX_W = clog2(DATA_W+1).
REQ-006 The block SHALL use one clock and an asynchronous, active-low reset, with ports as follows.
REQ-007 clk  input  1  rising-edge clock.
REQ-008 rstN  input  1  asynchronous active-low reset.
REQ-009 sampleValid  input  1  sample offered.
REQ-010 sampleChannel  input  CH_W  channel of offered sample.
REQ-011 bloodSensor  input  DATA_W  signed sample.
REQ-012 clearAlarm  input  CHANNELS  per-channel alarm clear pulse.
REQ-013 sampleReady  output  1  block can accept a sample.
REQ-014 resultValid  output  1  one-cycle result strobe.
REQ-015 resultChannel  output  CH_W  channel of current result.
REQ-016 glycemicIndex  output  IDX_W  popcount of |sample|.
REQ-017 avgIndex  output  IDX_W  floor(window sum / WINDOW) for resultChannel.
REQ-018 chanErr  output  1  result belongs to an out-of-range channel.
REQ-019 alarm  output  CHANNELS  sticky per-channel alarm flags.

Function
REQ-020 The FSM SHALL have states IDLE, ABS, COUNT, UPDATE and DONE; sampleReady SHALL be 1 only in IDLE.
REQ-021 On a rising edge with sampleValid=1 and sampleReady=1, the block SHALL latch the sample and channel and enter ABS; sampleValid outside IDLE SHALL be ignored.
REQ-022 ABS (1 cycle) SHALL latch the magnitude: the sample if its MSB is 0, otherwise its bitwise inverse plus 1, taken as DATA_W-bit unsigned (so -2^(DATA_W-1) gives magnitude 2^(DATA_W-1)).
REQ-023 COUNT SHALL last exactly DATA_W cycles, shifting the magnitude one bit per cycle and incrementing a counter on each 1 bit.
REQ-024 UPDATE (1 cycle) SHALL register glycemicIndex, resultChannel, chanErr and avgIndex for the DONE cycle.
REQ-025 In UPDATE, for a valid channel, the block SHALL push the index into that channel's WINDOW-deep history, evict the oldest entry, and update the running sum (width IDX_W+clog2(WINDOW)); avgIndex SHALL be the new sum right-shifted by log2(WINDOW).
REQ-026 History entries SHALL reset to 0, and the divisor SHALL always be WINDOW, including before the window has filled.
REQ-027 If sampleChannel >= CHANNELS, the block SHALL modify no history or alarm, set chanErr=1 and avgIndex=0, and still report glycemicIndex.
REQ-028 resultValid SHALL be 1 exactly during DONE, and DONE SHALL always go to IDLE; with DATA_W=8, resultValid is high in the cycle after the 10th edge following acceptance.
REQ-029 Outputs resultChannel, glycemicIndex, avgIndex and chanErr SHALL hold their values until the next UPDATE.
REQ-030 In UPDATE, alarm[c] SHALL be set when the new avgIndex >= ALARM_TH; a clearAlarm[c] pulse SHALL clear it; if both occur in the same cycle, the set SHALL win.
REQ-031 clearAlarm SHALL act in any state, on every channel independently.

Reset
REQ-032 When rstN=0, the block SHALL immediately set the FSM to IDLE, clear all history, sums and alarms, and drive resultValid, resultChannel, glycemicIndex, avgIndex and chanErr to 0.
REQ-033 sampleReady SHALL be 1 from the first cycle after reset is released, and a reset during any state SHALL abort the operation with no resultValid issued.

Verification (DATA_W=8, CHANNELS=4, WINDOW=4, ALARM_TH=4 unless stated)
REQ-034 Reset release -> all outputs 0, sampleReady=1.
REQ-035 Sample 0x7F on channel 0 -> sampleReady low for 11 cycles, then one resultValid cycle with glycemicIndex=7, avgIndex=1, chanErr=0.
REQ-036 Samples 0x80, 0xFF, 0x00 -> glycemicIndex 1, 1, 0.
REQ-037 Four 0x7F samples on channel 2 -> avgIndex 1, 3, 5, 7; alarm[2] rises at the third result; other alarm bits stay 0; a clearAlarm[2] pulse at the fourth UPDATE leaves alarm[2]=1.
REQ-038 With CHANNELS=3, a sample on channel 3 -> chanErr=1, avgIndex=0, and channel 0-2 averages unchanged.
REQ-039 rstN pulsed low during COUNT -> outputs 0 immediately, no resultValid, sampleReady=1 after release, and the next sample completes normally.
